// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
//
// Walks a pixel counter (hCount) across each line and a line counter (vCount)
// down each frame. It drives blank, hsync and vsync for the count pair shown
// in the same cycle, and pulses frame_start when the raster re-enters (0,0).
//
// Build option: define VGA_FRAME_CNT_EN to add a 16-bit frameCount output.
// frameCount counts completed frames and wraps from 65535 to 0.
//
// Ports:
//   clk_25mhz   in   pixel clock
//   reset       in   asynchronous, active-low reset
//   en          in   advance enable; all state holds while low
//   hCount      out  [10:0] current pixel column
//   vCount      out  [10:0] current line
//   blank       out  high outside the visible area
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   frame_start out  one-cycle pulse in the cycle the counts are (0,0) after a frame wrap
//   frameCount  out  [15:0] completed-frame count (VGA_FRAME_CNT_EN only)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        en,
  output logic [10:0] hCount,
  output logic [10:0] vCount,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START = 11'(H_VISIBLE);
  localparam logic [10:0] H_SY_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_BP_START = 11'(H_VISIBLE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START = 11'(V_VISIBLE);
  localparam logic [10:0] V_SY_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_BP_START = 11'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

  h_state_t    h_state, h_state_nxt;
  v_state_t    v_state, v_state_nxt;
  logic        h_wrap, v_wrap;
  logic [10:0] h_cnt_nxt, v_cnt_nxt;
  logic        blank_nxt, hsync_nxt, vsync_nxt;

  // Phase FSMs and outputs are computed from the post-edge counts. Registering
  // them therefore lines the outputs up with the counts in the same cycle.
  always_comb begin
    h_wrap    = (hCount == H_LAST);
    v_wrap    = (vCount == V_LAST);
    h_cnt_nxt = h_wrap ? '0 : hCount + 11'd1;
    v_cnt_nxt = vCount;
    if (h_wrap) begin
      v_cnt_nxt = v_wrap ? '0 : vCount + 11'd1;
    end

    h_state_nxt = h_state;
    case (h_state)
      H_ACT:   if (h_cnt_nxt == H_FP_START) h_state_nxt = H_FRONT;
      H_FRONT: if (h_cnt_nxt == H_SY_START) h_state_nxt = H_SYNCP;
      H_SYNCP: if (h_cnt_nxt == H_BP_START) h_state_nxt = H_BACK;
      H_BACK:  if (h_cnt_nxt == '0)         h_state_nxt = H_ACT;
      default: h_state_nxt = H_ACT;
    endcase

    v_state_nxt = v_state;
    if (h_wrap) begin
      case (v_state)
        V_ACT:   if (v_cnt_nxt == V_FP_START) v_state_nxt = V_FRONT;
        V_FRONT: if (v_cnt_nxt == V_SY_START) v_state_nxt = V_SYNCP;
        V_SYNCP: if (v_cnt_nxt == V_BP_START) v_state_nxt = V_BACK;
        V_BACK:  if (v_cnt_nxt == '0)         v_state_nxt = V_ACT;
        default: v_state_nxt = V_ACT;
      endcase
    end

    blank_nxt = (h_state_nxt != H_ACT) || (v_state_nxt != V_ACT);
    hsync_nxt = (h_state_nxt != H_SYNCP);
    vsync_nxt = (v_state_nxt != V_SYNCP);
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      hCount      <= '0;
      vCount      <= '0;
      blank       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else if (en) begin
      h_state     <= h_state_nxt;
      v_state     <= v_state_nxt;
      hCount      <= h_cnt_nxt;
      vCount      <= v_cnt_nxt;
      blank       <= blank_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= h_wrap && v_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      frameCount <= '0;
    end else if (en && h_wrap && v_wrap) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk_25mhz, input, 1, the single pixel clock.
REQ-010 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port en, input, 1, advance enable; counters advance only when high.
REQ-012 SHALL have port hCount, output, 11, current pixel column.
REQ-013 SHALL have port vCount, output, 11, current line.
REQ-014 SHALL have port blank, output, 1, high outside the visible area.
REQ-015 SHALL have port hsync, output, 1, active-low horizontal sync.
REQ-016 SHALL have port vsync, output, 1, active-low vertical sync.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse on entry to (0,0).

Function
REQ-018 SHALL define H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-019 SHALL, on each clk_25mhz rising edge with en=1, increment hCount; at hCount=H_TOTAL-1, wrap hCount to 0 and increment vCount.
REQ-020 SHALL wrap vCount to 0 when hCount=H_TOTAL-1 and vCount=V_TOTAL-1 on the same edge.
REQ-021 SHALL hold hCount, vCount, blank, hsync, vsync when en=0, and drive frame_start=0.
REQ-022 SHALL implement a horizontal phase FSM with states H_ACT, H_FRONT, H_SYNCP, H_BACK. Transitions occur on the edge where hCount enters H_VISIBLE, H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC, and 0 respectively.
REQ-023 SHALL implement a vertical phase FSM with states V_ACT, V_FRONT, V_SYNCP, V_BACK. It uses the same boundaries applied to vCount and advances only on the hCount wrap edge.
REQ-024 SHALL register blank, hsync and vsync so that each is valid for the hCount/vCount value present in the same cycle. There SHALL be zero cycles of skew between counts and control outputs.
REQ-025 SHALL drive blank=1 iff hCount>=H_VISIBLE or vCount>=V_VISIBLE.
REQ-026 SHALL drive hsync=0 iff H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-027 SHALL drive vsync=0 iff V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491), for the full duration of those lines.
REQ-028 SHALL assert frame_start for exactly the one cycle after the REQ-020 wrap edge (counts = 0,0). It SHALL NOT assert on the cycle after reset release.
REQ-029 SHALL never present hCount>=H_TOTAL or vCount>=V_TOTAL.

Reset
REQ-030 SHALL, while reset=0 and regardless of clock, force hCount=0, vCount=0, blank=0, hsync=1, vsync=1, frame_start=0, and FSMs to H_ACT/V_ACT.
REQ-031 SHALL, when reset is asserted mid-line or mid-frame, abandon the frame immediately, then restart from (0,0) on the first enabled edge after release.

Configuration
REQ-032 SHALL, when VGA_FRAME_CNT_EN is defined, add output port frameCount (16 bits). It resets to 0, increments on the REQ-020 wrap edge, and wraps from 65535 to 0.
REQ-033 SHALL, when VGA_FRAME_CNT_EN is undefined, omit frameCount and its register entirely. All other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover reset: hold reset=0 for 5 cycles, then release with en=1 -> hCount=0, vCount=0, hsync=1, vsync=1, blank=0, frame_start=0 before the first edge; hCount=1 after the first edge.
REQ-035 SHALL cover line timing: run 800 cycles -> blank rises at hCount=640; hsync low for hCount 656..751 (96 cycles); hCount wraps 799->0 with vCount 0->1.
REQ-036 SHALL cover frame timing: run 420000 cycles -> vsync low for vCount 490..491 (1600 cycles); blank high for all of vCount 480..524; frame_start pulses once, at cycle 420000 with counts (0,0).
REQ-037 SHALL cover enable: drive en=0 for 10 cycles at hCount=655 -> all outputs frozen and hsync=1; after en=1, the next edge gives hCount=656 and hsync=0.
REQ-038 SHALL cover mid-frame reset: assert reset at (300,200) -> outputs reach reset values without a clock edge; after release, no frame_start until a full 420000-cycle frame completes.
REQ-039 SHALL, with VGA_FRAME_CNT_EN defined, cover the frame counter: run 3 frames -> frameCount=3; with frameCount preloaded by force to 65535, one wrap -> 0.
